// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: 640x480@60 raster counters, blank, line/frame strobes and delayed hs/vs.
// Define VGA_FRAME_COUNT_EN to add the 8-bit frame_count output.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  if (H_TOTAL > 1024) begin : g_h_check
    $error("vga_timing_gen: H_TOTAL exceeds 10-bit counter range");
  end
  if (V_TOTAL > 1024) begin : g_v_check
    $error("vga_timing_gen: V_TOTAL exceeds 10-bit counter range");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_d_check
    $error("vga_timing_gen: SYNC_DELAY must be 0..3");
  end

  logic [9:0] hc;
  logic [9:0] vc;
  logic       hs_raw;
  logic       vs_raw;

  // vc only moves on the hc wrap edge, so both wrap together at frame end
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else if (hc == H_MAX) begin
      hc <= 10'd0;
      vc <= (vc == V_MAX) ? 10'd0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign blank       = (hc < H_VIS_L) && (vc < V_VIS_L);
  assign line_start  = (hc == 10'd0);
  assign frame_start = (hc == 10'd0) && (vc == 10'd0);

  assign hs_raw = ((hc >= HS_START) && (hc < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw = ((vc >= VS_START) && (vc < VS_END)) ? SYNC_POL : ~SYNC_POL;

  // Delay hs/vs to line up with the renderer's registered colour output
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign hs = hs_raw;
    assign vs = vs_raw;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hs_pipe;
    logic [SYNC_DELAY-1:0] vs_pipe;

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_pipe <= {SYNC_DELAY{~SYNC_POL}};
        vs_pipe <= {SYNC_DELAY{~SYNC_POL}};
      end else begin
        for (int i = SYNC_DELAY - 1; i > 0; i--) begin
          hs_pipe[i] <= hs_pipe[i-1];
          vs_pipe[i] <= vs_pipe[i-1];
        end
        hs_pipe[0] <= hs_raw;
        vs_pipe[0] <= vs_raw;
      end
    end

    assign hs = hs_pipe[SYNC_DELAY-1];
    assign vs = vs_pipe[SYNC_DELAY-1];
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 8'd0;
    end else if ((hc == H_MAX) && (vc == V_MAX)) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: a reduced-geometry instance checked every cycle against a
// reference model (sync delay via an expected-value queue) plus directed 640x480 checks.
module tb_vga_timing_gen;

  localparam int SH_VIS = 16, SH_FP = 4, SH_SYNC = 8, SH_BP = 4;
  localparam int SV_VIS = 4,  SV_FP = 1, SV_SYNC = 2, SV_BP = 1;
  localparam int SH_TOT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
  localparam int SV_TOT = SV_VIS + SV_FP + SV_SYNC + SV_BP;
  localparam int S_DELAY = 2;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] sx, sy, fx, fy;
  logic       sblank, shs, svs, sls, sfs;
  logic       fblank, fhs, fvs, fls, ffs;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] sfc, ffc;
`endif

  int compared   = 0;
  int mismatched = 0;
  int mhc, mvc, mfc;
  logic [1:0] sync_q[$];

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_VISIBLE(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .SYNC_POL(1'b0), .SYNC_DELAY(S_DELAY)
  ) dut_small (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(sx), .DrawY(sy), .blank(sblank),
    .hs(shs), .vs(svs), .line_start(sls), .frame_start(sfs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(sfc)
`endif
  );

  vga_timing_gen dut_full (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(fx), .DrawY(fy), .blank(fblank),
    .hs(fhs), .vs(fvs), .line_start(fls), .frame_start(ffs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(ffc)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  function automatic logic raw_hs(input int hc);
    return (hc >= SH_VIS + SH_FP && hc < SH_VIS + SH_FP + SH_SYNC) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic raw_vs(input int vc);
    return (vc >= SV_VIS + SV_FP && vc < SV_VIS + SV_FP + SV_SYNC) ? 1'b0 : 1'b1;
  endfunction

  task automatic model_reset();
    mhc = 0;
    mvc = 0;
    mfc = 0;
    sync_q.delete();
    repeat (S_DELAY) sync_q.push_back(2'b11);
  endtask

  task automatic model_advance();
    if (mhc == SH_TOT - 1) begin
      mhc = 0;
      if (mvc == SV_TOT - 1) begin
        mvc = 0;
        mfc = (mfc + 1) % 256;
      end else begin
        mvc++;
      end
    end else begin
      mhc++;
    end
  endtask

  task automatic check_small();
    logic [1:0] exp_sync;
    sync_q.push_back({raw_hs(mhc), raw_vs(mvc)});
    exp_sync = sync_q.pop_front();
    check_output("small_DrawX", sx, mhc);
    check_output("small_DrawY", sy, mvc);
    check_output("small_blank", sblank, (mhc < SH_VIS) && (mvc < SV_VIS));
    check_output("small_line_start", sls, mhc == 0);
    check_output("small_frame_start", sfs, (mhc == 0) && (mvc == 0));
    check_output("small_hs", shs, exp_sync[1]);
    check_output("small_vs", svs, exp_sync[0]);
`ifdef VGA_FRAME_COUNT_EN
    check_output("small_frame_count", sfc, mfc);
`endif
  endtask

  task automatic apply_stimulus();
    @(posedge vga_clk);
    #1;
    if (reset_n) model_advance();
    check_small();
  endtask

  task automatic wait_full_x(input int x, input string tag);
    int n = 0;
    while (fx !== 10'(x) && n < 1000) begin
      apply_stimulus();
      n++;
    end
    check_output(tag, fx, x);
  endtask

  task automatic check_full_reset(input string tag);
    check_output({tag, "_DrawX"}, fx, 0);
    check_output({tag, "_DrawY"}, fy, 0);
    check_output({tag, "_hs"}, fhs, 1);
    check_output({tag, "_vs"}, fvs, 1);
    check_output({tag, "_blank"}, fblank, 1);
    check_output({tag, "_line_start"}, fls, 1);
    check_output({tag, "_frame_start"}, ffs, 1);
  endtask

  initial begin
    int w, p, y, n;
    reset_n = 1'b1;
    model_reset();
    #2 reset_n = 1'b0;
    #3;
    $display("[TB] reset state");
    check_small();
    check_full_reset("full_reset");
    repeat (3) apply_stimulus();

    reset_n = 1'b1;
    #1;
    check_output("full_frame_start_after_release", ffs, 1);
    check_output("small_frame_start_after_release", sfs, 1);

    $display("[TB] horizontal timing at 640x480");
    wait_full_x(656, "full_reach_656");
    check_output("full_hs_high_at_656", fhs, 1);
    apply_stimulus();
    check_output("full_hs_low_at_657", fhs, 0);
    w = 0;
    while (fhs === 1'b0 && w < 200) begin
      w++;
      apply_stimulus();
    end
    check_output("full_hs_low_width", w, 96);
    check_output("full_hs_rise_at_753", fx, 753);
    p = 0;
    while (fhs !== 1'b0 && p < 1000) begin
      apply_stimulus();
      p++;
    end
    check_output("full_hs_period", w + p, 800);

    $display("[TB] line wrap and blank at 640x480");
    wait_full_x(639, "full_reach_639");
    check_output("full_blank_at_639", fblank, 1);
    apply_stimulus();
    check_output("full_blank_at_640", fblank, 0);
    wait_full_x(799, "full_reach_799");
    y = int'(fy);
    check_output("full_line_start_at_799", fls, 0);
    apply_stimulus();
    check_output("full_wrap_DrawX", fx, 0);
    check_output("full_wrap_DrawY", fy, y + 1);
    check_output("full_line_start_pulse", fls, 1);
    apply_stimulus();
    check_output("full_line_start_single", fls, 0);

    $display("[TB] small frame wrap");
    n = 0;
    while (!(sx == 10'(SH_TOT - 1) && sy == 10'(SV_TOT - 1)) && n < 1000) begin
      apply_stimulus();
      n++;
    end
    check_output("small_reach_frame_end", {sy, sx}, {10'(SV_TOT - 1), 10'(SH_TOT - 1)});
    apply_stimulus();
    check_output("small_frame_wrap_start", sfs, 1);

    $display("[TB] mid-frame reset");
    n = 0;
    while (!(sx == 10'd10 && sy == 10'd3) && n < 1000) begin
      apply_stimulus();
      n++;
    end
    check_output("small_reach_mid", {sy, sx}, {10'd3, 10'd10});
    reset_n = 1'b0;
    #1;
    model_reset();
    check_small();
    check_full_reset("full_midreset");
    repeat (2) apply_stimulus();
    reset_n = 1'b1;
    #1;
    check_output("small_frame_start_after_midreset", sfs, 1);
    check_output("full_frame_start_after_midreset", ffs, 1);
`ifdef VGA_FRAME_COUNT_EN
    check_output("full_frame_count_reset", ffc, 0);
    $display("[TB] 256 frames of frame_count");
    repeat (256 * SH_TOT * SV_TOT - 1) apply_stimulus();
    check_output("small_frame_count_255", sfc, 255);
    apply_stimulus();
    check_output("small_frame_count_wrapped", sfc, 0);
`else
    repeat (2 * SH_TOT * SV_TOT) apply_stimulus();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
